wb_slave_port_n: RTL and testbench



---
 rtl/wb_slave_port_n.sv | 166 ++++++++++++++++
 tb/tb_wb_slave_port_n.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_port_n.sv
// N-master to 1-slave Wishbone port: round-robin arbitration on target ID,
// burst-long grant hold, and an ack timeout that returns err to the master.
module wb_slave_port_n #(
    parameter int unsigned NUM_MST = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned BLW     = 10,
    parameter int unsigned TO_CYC  = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic [3:0]                   cfg_slave_id,
    input  logic [NUM_MST*DW-1:0]        m_wbd_dat_i,
    input  logic [NUM_MST*AW-1:0]        m_wbd_adr_i,
    input  logic [NUM_MST*(DW/8)-1:0]    m_wbd_sel_i,
    input  logic [NUM_MST*BLW-1:0]       m_wbd_bl_i,
    input  logic [NUM_MST-1:0]           m_wbd_bry_i,
    input  logic [NUM_MST-1:0]           m_wbd_we_i,
    input  logic [NUM_MST-1:0]           m_wbd_cyc_i,
    input  logic [NUM_MST-1:0]           m_wbd_stb_i,
    input  logic [NUM_MST*4-1:0]         m_wbd_tid_i,
    output logic [NUM_MST*DW-1:0]        m_wbd_dat_o,
    output logic [NUM_MST-1:0]           m_wbd_ack_o,
    output logic [NUM_MST-1:0]           m_wbd_lack_o,
    output logic [NUM_MST-1:0]           m_wbd_err_o,
    input  logic [DW-1:0]                s_wbd_dat_i,
    input  logic                         s_wbd_ack_i,
    input  logic                         s_wbd_lack_i,
    input  logic                         s_wbd_err_i,
    output logic [DW-1:0]                s_wbd_dat_o,
    output logic [AW-1:0]                s_wbd_adr_o,
    output logic [DW/8-1:0]              s_wbd_sel_o,
    output logic [BLW-1:0]               s_wbd_bl_o,
    output logic                         s_wbd_bry_o,
    output logic                         s_wbd_we_o,
    output logic                         s_wbd_cyc_o,
    output logic                         s_wbd_stb_o,
    output logic [$clog2(NUM_MST)-1:0]   gnt_o
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned GW = $clog2(NUM_MST);

    typedef enum logic [1:0] {StIdle, StBusy, StTurn} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [15:0]   cnt_q, cnt_d;

    logic [NUM_MST-1:0] req;
    logic               arb_hit;
    logic [GW-1:0]      arb_idx;
    int unsigned        idx;
    int unsigned        gi;
    logic               timeout;
    logic [BLW-1:0]     g_bl;
    logic               unused_cyc;

    // cyc is implied by stb on this fabric; only stb qualifies a request.
    assign unused_cyc = ^m_wbd_cyc_i;

    always_comb begin
        for (int k = 0; k < int'(NUM_MST); k++) begin
            req[k] = m_wbd_stb_i[k] && (m_wbd_tid_i[k*4 +: 4] == cfg_slave_id);
        end
    end

    // Rotating priority: search upward from the slot after the last winner.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        idx     = 0;
        for (int unsigned i = 1; i <= NUM_MST; i++) begin
            idx = (32'(ptr_q) + i) % NUM_MST;
            if (!arb_hit && req[idx[GW-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = idx[GW-1:0];
            end
        end
    end

    assign gi      = 32'(gnt_q);
    assign timeout = (cnt_q == 16'(TO_CYC - 1));
    assign g_bl    = m_wbd_bl_i[gi*BLW +: BLW];
    assign gnt_o   = gnt_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        m_wbd_dat_o  = '0;
        m_wbd_ack_o  = '0;
        m_wbd_lack_o = '0;
        m_wbd_err_o  = '0;
        s_wbd_dat_o  = '0;
        s_wbd_adr_o  = '0;
        s_wbd_sel_o  = '0;
        s_wbd_bl_o   = '0;
        s_wbd_bry_o  = 1'b0;
        s_wbd_we_o   = 1'b0;
        s_wbd_cyc_o  = 1'b0;
        s_wbd_stb_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_hit) begin
                    gnt_d   = arb_idx;
                    ptr_d   = arb_idx;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!m_wbd_stb_i[gi]) begin
                    // Master abandoned the cycle: release without any response.
                    state_d = StTurn;
                end else begin
                    s_wbd_dat_o = m_wbd_dat_i[gi*DW +: DW];
                    s_wbd_adr_o = {m_wbd_adr_i[gi*AW+2 +: AW-2], 2'b00};
                    s_wbd_sel_o = m_wbd_sel_i[gi*SW +: SW];
                    s_wbd_bl_o  = (g_bl == '0) ? BLW'(1) : g_bl;
                    s_wbd_bry_o = m_wbd_bry_i[gi];
                    s_wbd_we_o  = m_wbd_we_i[gi];
                    s_wbd_cyc_o = 1'b1;
                    s_wbd_stb_o = 1'b1;
                    m_wbd_dat_o[gi*DW +: DW] = s_wbd_dat_i;
                    if (timeout) begin
                        m_wbd_err_o[gi]  = 1'b1;
                        m_wbd_lack_o[gi] = 1'b1;
                        state_d          = StTurn;
                    end else begin
                        m_wbd_ack_o[gi]  = s_wbd_ack_i;
                        m_wbd_lack_o[gi] = s_wbd_lack_i | s_wbd_err_i;
                        m_wbd_err_o[gi]  = s_wbd_err_i;
                        cnt_d            = s_wbd_ack_i ? '0 : cnt_q + 16'd1;
                        if (s_wbd_lack_i || s_wbd_err_i) begin
                            state_d = StTurn;
                        end
                    end
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= GW'(NUM_MST - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_slave_port_n.sv
// Directed bench for wb_slave_port_n (4 masters, 8-cycle timeout).
module tb_wb_slave_port_n;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BLW = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        cfg_slave_id;
    logic [NM*DW-1:0]  m_dat_i;
    logic [NM*AW-1:0]  m_adr_i;
    logic [NM*4-1:0]   m_sel_i;
    logic [NM*BLW-1:0] m_bl_i;
    logic [NM-1:0]     m_bry_i, m_we_i, m_cyc_i, m_stb_i;
    logic [NM*4-1:0]   m_tid_i;
    logic [NM*DW-1:0]  m_dat_o;
    logic [NM-1:0]     m_ack_o, m_lack_o, m_err_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_lack_i, s_err_i;
    logic [DW-1:0]     s_dat_o;
    logic [AW-1:0]     s_adr_o;
    logic [3:0]        s_sel_o;
    logic [BLW-1:0]    s_bl_o;
    logic              s_bry_o, s_we_o, s_cyc_o, s_stb_o;
    logic [1:0]        gnt_o;

    int checks = 0;
    int errors = 0;

    wb_slave_port_n #(.NUM_MST(NM), .AW(AW), .DW(DW), .BLW(BLW), .TO_CYC(8)) dut (
        .clk_i(clk), .rst_n(rst_n), .cfg_slave_id(cfg_slave_id),
        .m_wbd_dat_i(m_dat_i), .m_wbd_adr_i(m_adr_i), .m_wbd_sel_i(m_sel_i),
        .m_wbd_bl_i(m_bl_i), .m_wbd_bry_i(m_bry_i), .m_wbd_we_i(m_we_i),
        .m_wbd_cyc_i(m_cyc_i), .m_wbd_stb_i(m_stb_i), .m_wbd_tid_i(m_tid_i),
        .m_wbd_dat_o(m_dat_o), .m_wbd_ack_o(m_ack_o), .m_wbd_lack_o(m_lack_o),
        .m_wbd_err_o(m_err_o), .s_wbd_dat_i(s_dat_i), .s_wbd_ack_i(s_ack_i),
        .s_wbd_lack_i(s_lack_i), .s_wbd_err_i(s_err_i), .s_wbd_dat_o(s_dat_o),
        .s_wbd_adr_o(s_adr_o), .s_wbd_sel_o(s_sel_o), .s_wbd_bl_o(s_bl_o),
        .s_wbd_bry_o(s_bry_o), .s_wbd_we_o(s_we_o), .s_wbd_cyc_o(s_cyc_o),
        .s_wbd_stb_o(s_stb_o), .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input logic stb, input logic [3:0] tid,
                         input logic [31:0] adr, input logic [9:0] bl,
                         input logic we, input logic [31:0] dat);
        m_stb_i[k] = stb;
        m_cyc_i[k] = stb;
        m_we_i[k]  = we;
        m_bry_i[k] = stb;
        m_tid_i[k*4 +: 4]     = tid;
        m_adr_i[k*AW +: AW]   = adr;
        m_bl_i[k*BLW +: BLW]  = bl;
        m_dat_i[k*DW +: DW]   = dat;
        m_sel_i[k*4 +: 4]     = 4'hF;
    endtask

    task automatic slv(input logic ack, input logic lack, input logic err, input logic [31:0] dat);
        s_ack_i = ack; s_lack_i = lack; s_err_i = err; s_dat_i = dat;
    endtask

    task automatic clr_all();
        m_dat_i = '0; m_adr_i = '0; m_sel_i = '0; m_bl_i = '0; m_tid_i = '0;
        m_bry_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
        slv(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
    int ng, last, acks;

    initial begin
        rst_n = 1'b0;
        cfg_slave_id = 4'd3;
        clr_all();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stb", s_stb_o, 0);
        chk("rst_cyc", s_cyc_o, 0);
        chk("rst_bl", s_bl_o, 0);
        chk("rst_bry", s_bry_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_mout", {m_ack_o, m_lack_o, m_err_o}, 0);
        chk("rst_mdat", m_dat_o, 0);

        // Single read from m2
        @(negedge clk);
        rst_n = 1'b1;
        set_m(2, 1'b1, 4'd3, 32'h1000_0007, 10'd1, 1'b0, 32'h0);
        #1 chk("rd_idle_stb", s_stb_o, 0);
        @(negedge clk); #1;
        chk("rd_stb", s_stb_o, 1);
        chk("rd_adr", s_adr_o, 32'h1000_0004);
        chk("rd_gnt", gnt_o, 2);
        chk("rd_bl", s_bl_o, 1);
        @(negedge clk); #1;
        chk("rd_noack", m_ack_o, 0);
        @(negedge clk);
        slv(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        #1;
        chk("rd_ack", m_ack_o, 4'b0100);
        chk("rd_lack", m_lack_o, 4'b0100);
        chk("rd_err", m_err_o, 0);
        chk("rd_dat", m_dat_o, {32'h0, 32'hDEAD_BEEF, 64'h0});
        @(negedge clk);
        clr_all();
        #1;
        chk("rd_turn_stb", s_stb_o, 0);
        chk("rd_turn_ack", m_ack_o, 0);
        repeat (2) @(negedge clk);

        // TID filter
        set_m(1, 1'b1, 4'd5, 32'h2000_0000, 10'd1, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("tid_stb", s_stb_o, 0);
            chk("tid_ack", m_ack_o, 0);
        end
        clr_all();

        // Round robin after reset: m0, m1, m3 continuously
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_m(0, 1'b1, 4'd3, 32'h0, 10'd1, 1'b0, 32'h0);
        set_m(1, 1'b1, 4'd3, 32'h0, 10'd1, 1'b0, 32'h0);
        set_m(3, 1'b1, 4'd3, 32'h0, 10'd1, 1'b0, 32'h0);
        ng = 0;
        last = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            slv(1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            if (s_stb_o) begin
                chk("rr_gnt", gnt_o, rr_exp[ng]);
                if (ng > 0) chk("rr_gap", c - last, 3);
                last = c;
                ng++;
                slv(1'b1, 1'b1, 1'b0, 32'h0);
            end
        end
        chk("rr_count", ng, 6);
        @(negedge clk);
        clr_all();
        repeat (3) @(negedge clk);

        // Burst hold: m0 writes 4 beats, m1 queues behind it
        set_m(0, 1'b1, 4'd3, 32'h3000_0000, 10'd4, 1'b1, 32'hCAFE_0000);
        acks = 0;
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            if (b == 1) set_m(1, 1'b1, 4'd3, 32'h4000_0000, 10'd0, 1'b0, 32'h0);
            slv(1'b1, b == 4, 1'b0, 32'h0);
            #1;
            chk("bu_bl", s_bl_o, 4);
            chk("bu_gnt", gnt_o, 0);
            chk("bu_ack", m_ack_o, 4'b0001);
            if (b == 1) begin
                chk("bu_wdat", s_dat_o, 32'hCAFE_0000);
                chk("bu_we", s_we_o, 1);
                chk("bu_sel", s_sel_o, 4'hF);
            end
            acks += int'(m_ack_o[0]);
        end
        chk("bu_acks", acks, 4);
        @(negedge clk);
        slv(1'b0, 1'b0, 1'b0, 32'h0);
        set_m(0, 1'b0, 4'd0, 32'h0, 10'd0, 1'b0, 32'h0);
        #1 chk("bu_turn", s_stb_o, 0);
        @(negedge clk); #1;
        chk("bu_idle", s_stb_o, 0);
        @(negedge clk); #1;
        chk("bu_m1_stb", s_stb_o, 1);
        chk("bu_m1_gnt", gnt_o, 1);
        chk("bu_bl0", s_bl_o, 1);
        slv(1'b1, 1'b1, 1'b0, 32'h0);
        #1 chk("bu_m1_ack", m_ack_o, 4'b0010);
        @(negedge clk);
        clr_all();
        repeat (3) @(negedge clk);

        // Timeout: m2 then m3, slave silent (ack on m3's last cycle is ignored)
        set_m(2, 1'b1, 4'd3, 32'h5000_0000, 10'd1, 1'b0, 32'h0);
        set_m(3, 1'b1, 4'd3, 32'h6000_0000, 10'd1, 1'b0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            chk("to2_stb", s_stb_o, 1);
            chk("to2_err", m_err_o, (k == 8) ? 4'b0100 : 4'b0000);
            chk("to2_lack", m_lack_o, (k == 8) ? 4'b0100 : 4'b0000);
        end
        @(negedge clk);
        set_m(2, 1'b0, 4'd0, 32'h0, 10'd0, 1'b0, 32'h0);
        #1;
        chk("to_turn_stb", s_stb_o, 0);
        chk("to_turn_err", m_err_o, 0);
        @(negedge clk); #1;
        chk("to_idle_stb", s_stb_o, 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            slv(k == 8, 1'b0, 1'b0, 32'h0);
            #1;
            if (k == 1) chk("to3_gnt", gnt_o, 3);
            chk("to3_err", m_err_o, (k == 8) ? 4'b1000 : 4'b0000);
            chk("to3_ack", m_ack_o, 0);
        end
        @(negedge clk);
        clr_all();
        #1 chk("to3_turn", s_stb_o, 0);
        repeat (2) @(negedge clk);

        // Reset during beat 2 of a 4-beat burst from m1
        set_m(1, 1'b1, 4'd3, 32'h7000_0000, 10'd4, 1'b0, 32'h0);
        @(negedge clk);
        slv(1'b1, 1'b0, 1'b0, 32'h0);
        #1 chk("rb_beat1", m_ack_o, 4'b0010);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rb_beat2", m_ack_o, 4'b0010);
        @(negedge clk); #1;
        chk("rb_stb", {s_stb_o, s_cyc_o}, 0);
        chk("rb_sout", {s_adr_o, s_bl_o, s_sel_o, s_we_o, s_bry_o}, 0);
        chk("rb_mout", {m_ack_o, m_lack_o, m_err_o}, 0);
        chk("rb_mdat", m_dat_o, 0);
        chk("rb_gnt", gnt_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        slv(1'b0, 1'b0, 1'b0, 32'h0);
        set_m(0, 1'b1, 4'd3, 32'h8000_0010, 10'd1, 1'b0, 32'h0);
        set_m(2, 1'b1, 4'd3, 32'h9000_0000, 10'd1, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk("rb_rearb_gnt", gnt_o, 0);
        chk("rb_rearb_adr", s_adr_o, 32'h8000_0010);
        slv(1'b1, 1'b1, 1'b0, 32'h0);
        #1 chk("rb_rearb_ack", m_ack_o, 4'b0001);
        @(negedge clk);
        clr_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
